umi_mem_arbiter: RTL and testbench
==================================

Name: umi_mem_arbiter

Overview:
- Shares the single UMI memory port among NUM_APPS application requesters using round-robin arbitration on MemReq.
- Records the app ID of every accepted read in an in-order tag FIFO and steers each returning MemResp to the app that issued it.
- Supports a quiescence handshake: stop granting, drain outstanding reads, acknowledge.
- Sits between the application slots and the shell UMI port.

Parameters:
- NUM_APPS, 4, number of requesters (2..8).
- ORDER_DEPTH, 16, maximum outstanding reads; power of two.
- APP_ID_WIDTH, $clog2(NUM_APPS), width of the tag stored per read.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- app_req  in  NUM_APPS x MemReq  per-app request; held until granted.
- app_grant  out  NUM_APPS  request accepted this cycle; at most one bit set.
- app_resp  out  NUM_APPS x MemResp  per-app read response.
- mem_req  out  MemReq  request to the UMI port.
- mem_grant  in  1  UMI port accepts mem_req this cycle.
- mem_resp  in  MemResp  in-order read data from the UMI port.
- quiesce_req  in  QuiescenceReq  valid with isRequest=1 starts a drain.
- quiesce_resp  out  QuiescenceResp  one-cycle valid when drained; data = total accepted reads (64b, wraps).
- resp_err  out  1  sticky: mem_resp.valid arrived while the tag FIFO was empty.

Behaviour:
- Reset values: all app_grant=0, app_resp=0, mem_req=0, quiesce_resp=0, resp_err=0, rr_ptr=0, FIFO empty, state=RUN.
- Reset is asynchronous, including mid-transaction. In-flight reads are forgotten; the shell resets the UMI side together with this block.
- Arbitration:
  - Candidates are apps with app_req[i].valid.
  - The winner is the first candidate at or after rr_ptr, modulo NUM_APPS.
  - A read winner is eligible only if the FIFO is not full; if it is full, that app is masked out and the next candidate wins.
- mem_req (combinational):
  - Equals the winner's request, valid only in state RUN.
  - With no eligible candidate, valid=0 and all other fields=0.
- Acceptance:
  - A request is accepted when mem_req.valid && mem_grant.
  - app_grant[winner] = accept, same cycle (zero-latency pass-through).
  - On accept, rr_ptr <= winner+1, wrapping NUM_APPS-1 to 0.
  - A read accept also pushes the winner ID into the FIFO and increments the read counter.
- Response routing:
  - On mem_resp.valid, pop the FIFO head; app_resp[head].valid=1 and data=mem_resp.data exactly one cycle later (registered). All other app_resp entries are valid=0.
  - Push and pop in the same cycle are both performed; occupancy is unchanged, including when full (the pop frees a slot).
  - Pop when empty: resp_err<=1, response dropped, pointers unchanged.
- Writes never push a tag and never produce a response.
- FIFO pointers are log2(ORDER_DEPTH)+1 bits. Full = MSBs differ and low bits equal.
- State machine:
  - RUN: normal operation. quiesce_req.valid && isRequest -> DRAIN.
  - DRAIN: mem_req.valid=0, so no grants. FIFO empty -> DONE.
  - DONE: quiesce_resp.valid=1 for one cycle -> QUIESCED.
  - QUIESCED: no grants. quiesce_req.valid && !isRequest (release) -> RUN.
  - quiesce_req in any other state/combination is ignored.
  - A quiesce request arriving in the same cycle as an accept: the accept completes, then the state changes.

Optional Feature:
- Macro: UMI_ARB_STATS_EN.
- Defined:
  - Adds output app_grant_cnt, NUM_APPS x 32b, counting accepts per app; saturates at 2^32-1.
  - Cleared by reset and on entry to QUIESCED.
- Undefined: the port and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package (ShellTypes): MemReq, MemResp, QuiescenceReq, QuiescenceResp, UMI widths.
- New in ShellTypes: typedef enum ArbState {RUN, DRAIN, DONE, QUIESCED}.
- Arbiter-local: ORDER_DEPTH, APP_ID_WIDTH.
- One sub-module: umi_tag_fifo, a parameterised synchronous FIFO with push/pop/full/empty that follows the same-cycle push/pop rule above.

Test Plan:
- All 4 apps hold a read, mem_grant=1 constantly, rr_ptr=0 -> grants in order 0,1,2,3,0, one per cycle. Responses D0..D3 return on app_resp[0..3], each 1 cycle after its mem_resp.
- App1 write + app2 read, rr_ptr=1 -> app1 granted first, no FIFO push; app2 next. Only app2 ever sees app_resp.valid.
- 16 reads accepted with no responses -> FIFO full and further reads masked, while an app3 write is still granted. Then a same-cycle mem_resp and read accept leaves occupancy at 16.
- mem_resp.valid with FIFO empty -> resp_err=1 and stays 1; no app_resp asserted.
- 3 reads outstanding, then quiesce_req{valid=1,isRequest=1} -> no grants. After the 3rd response, quiesce_resp.valid pulses for 1 cycle with data=3. Release -> grants resume.
- rst_n low for 1 cycle with 5 reads outstanding -> all outputs 0 immediately, FIFO empty, state RUN.

Source files
------------

// File: rtl/ShellTypes.sv
// Shared shell types: UMI memory request/response, quiescence handshake
// structs and the arbiter state encoding.
package ShellTypes;
  localparam int UMI_ADDR_W = 64;
  localparam int UMI_DATA_W = 64;

  typedef struct packed {
    logic                  valid;
    logic                  isWrite;
    logic [UMI_ADDR_W-1:0] addr;
    logic [UMI_DATA_W-1:0] data;
  } MemReq;

  typedef struct packed {
    logic                  valid;
    logic [UMI_DATA_W-1:0] data;
  } MemResp;

  typedef struct packed {
    logic valid;
    logic isRequest;
  } QuiescenceReq;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } QuiescenceResp;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    DONE     = 2'd2,
    QUIESCED = 2'd3
  } ArbState;
endpackage

// File: rtl/umi_tag_fifo.sv
// In-order tag FIFO. A pop in the same cycle as a push frees the slot the
// push needs, so push+pop while full keeps occupancy unchanged.
module umi_tag_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop_ok, push_ok;

  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o    = wr_ptr_q - rd_ptr_q;
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign pop_ok     = pop_i && !empty_o;
  assign push_ok    = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end
endmodule

// File: rtl/umi_mem_arbiter.sv
// Round-robin arbiter sharing one UMI memory port, with in-order response
// steering and a quiesce/drain handshake. UMI_ARB_STATS_EN adds per-app grant counters.
module umi_mem_arbiter
  import ShellTypes::*;
#(
  parameter int NUM_APPS     = 4,
  parameter int ORDER_DEPTH  = 16,
  parameter int APP_ID_WIDTH = $clog2(NUM_APPS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  MemReq                          app_req [NUM_APPS],
  output logic [NUM_APPS-1:0]            app_grant,
  output MemResp                         app_resp [NUM_APPS],
  output MemReq                          mem_req,
  input  logic                           mem_grant,
  input  MemResp                         mem_resp,
  input  QuiescenceReq                   quiesce_req,
  output QuiescenceResp                  quiesce_resp,
  output logic                           resp_err,
`ifdef UMI_ARB_STATS_EN
  output logic [31:0]                    app_grant_cnt [NUM_APPS],
`endif
  output ArbState                        dbg_state,
  output logic [$clog2(ORDER_DEPTH):0]   dbg_fifo_cnt
);
  localparam logic [APP_ID_WIDTH:0]   NUM_APPS_W = (APP_ID_WIDTH+1)'(NUM_APPS);
  localparam logic [APP_ID_WIDTH-1:0] LAST_ID    = APP_ID_WIDTH'(NUM_APPS - 1);

  ArbState                 state_q, state_d;
  logic [APP_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [NUM_APPS-1:0]     eligible;
  logic [APP_ID_WIDTH:0]   cand;
  logic [APP_ID_WIDTH-1:0] win, head_id;
  logic                    found, accept, rd_accept, pop_ok;
  logic                    fifo_full, fifo_empty;
  logic                    resp_vld_q, resp_err_q;
  logic [APP_ID_WIDTH-1:0] resp_id_q;
  logic [UMI_DATA_W-1:0]   resp_data_q;
  logic [63:0]             rd_cnt_q;

  // A full FIFO still admits a read when a response pops a tag this cycle.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_APPS; i++)
      eligible[i] = app_req[i].valid &&
                    (app_req[i].isWrite || !fifo_full || mem_resp.valid);
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_APPS; k++) begin
      cand = {1'b0, rr_ptr_q} + (APP_ID_WIDTH+1)'(k);
      if (cand >= NUM_APPS_W) cand = cand - NUM_APPS_W;
      if (!found && eligible[cand[APP_ID_WIDTH-1:0]]) begin
        found = 1'b1;
        win   = cand[APP_ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    mem_req = '0;
    if (state_q == RUN && found) mem_req = app_req[win];
  end

  assign accept    = mem_req.valid && mem_grant;
  assign rd_accept = accept && !mem_req.isWrite;
  assign pop_ok    = mem_resp.valid && !fifo_empty;
  assign rr_ptr_d  = (win == LAST_ID) ? '0 : win + 1'b1;

  always_comb begin
    app_grant = '0;
    if (accept) app_grant[win] = 1'b1;
  end

  umi_tag_fifo #(.DEPTH(ORDER_DEPTH), .WIDTH(APP_ID_WIDTH)) u_tag_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (rd_accept),
    .push_data_i (win),
    .pop_i       (mem_resp.valid),
    .pop_data_o  (head_id),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (dbg_fifo_cnt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (quiesce_req.valid && quiesce_req.isRequest) state_d = DRAIN;
      DRAIN:    if (fifo_empty) state_d = DONE;
      DONE:     state_d = QUIESCED;
      QUIESCED: if (quiesce_req.valid && !quiesce_req.isRequest) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      rr_ptr_q    <= '0;
      resp_vld_q  <= 1'b0;
      resp_id_q   <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      rd_cnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      resp_vld_q <= pop_ok;
      if (accept)    rr_ptr_q <= rr_ptr_d;
      if (rd_accept) rd_cnt_q <= rd_cnt_q + 64'd1;
      if (pop_ok) begin
        resp_id_q   <= head_id;
        resp_data_q <= mem_resp.data;
      end
      if (mem_resp.valid && fifo_empty) resp_err_q <= 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_APPS; i++) begin
      app_resp[i] = '0;
      if (resp_vld_q && resp_id_q == APP_ID_WIDTH'(i)) begin
        app_resp[i].valid = 1'b1;
        app_resp[i].data  = resp_data_q;
      end
    end
  end

  always_comb begin
    quiesce_resp = '0;
    if (state_q == DONE) begin
      quiesce_resp.valid = 1'b1;
      quiesce_resp.data  = rd_cnt_q;
    end
  end

  assign resp_err  = resp_err_q;
  assign dbg_state = state_q;

`ifdef UMI_ARB_STATS_EN
  logic [31:0] cnt_q [NUM_APPS];

  // Counters restart at every entry into QUIESCED; they saturate rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_APPS; i++) cnt_q[i] <= '0;
    end else if (state_d == QUIESCED && state_q != QUIESCED) begin
      for (int i = 0; i < NUM_APPS; i++) cnt_q[i] <= '0;
    end else if (accept && cnt_q[win] != 32'hFFFF_FFFF) begin
      cnt_q[win] <= cnt_q[win] + 32'd1;
    end
  end

  assign app_grant_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_umi_mem_arbiter.sv
// Scoreboard bench for umi_mem_arbiter: directed stimulus pushes expected
// grants/responses/quiesce data; a negedge monitor pops and compares.
module tb_umi_mem_arbiter;
  import ShellTypes::*;

  localparam int NUM_APPS    = 4;
  localparam int ORDER_DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  MemReq         app_req [NUM_APPS];
  logic [3:0]    app_grant;
  MemResp        app_resp [NUM_APPS];
  MemReq         mem_req;
  logic          mem_grant;
  MemResp        mem_resp;
  QuiescenceReq  quiesce_req;
  QuiescenceResp quiesce_resp;
  logic          resp_err;
  ArbState       dbg_state;
  logic [4:0]    dbg_fifo_cnt;
`ifdef UMI_ARB_STATS_EN
  logic [31:0]   app_grant_cnt [NUM_APPS];
`endif

  umi_mem_arbiter #(.NUM_APPS(NUM_APPS), .ORDER_DEPTH(ORDER_DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .app_req      (app_req),
    .app_grant    (app_grant),
    .app_resp     (app_resp),
    .mem_req      (mem_req),
    .mem_grant    (mem_grant),
    .mem_resp     (mem_resp),
    .quiesce_req  (quiesce_req),
    .quiesce_resp (quiesce_resp),
    .resp_err     (resp_err),
`ifdef UMI_ARB_STATS_EN
    .app_grant_cnt(app_grant_cnt),
`endif
    .dbg_state    (dbg_state),
    .dbg_fifo_cnt (dbg_fifo_cnt)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_grant_q[$];
  logic [7:0]  exp_resp_id_q[$];
  logic [63:0] exp_resp_data_q[$];
  logic [63:0] exp_qr_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0]  mon_id;
  logic [63:0] mon_data;
  logic [3:0]  mon_rv;

  always @(negedge clk) begin
    if (rst_n) begin
      if (app_grant != 4'd0) begin
        if (exp_grant_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_grant: got %b expected none", app_grant);
        end else begin
          mon_id = exp_grant_q.pop_front();
          check("grant", 64'(app_grant), 64'(4'b0001 << mon_id[1:0]));
          check("mem_req_addr", mem_req.addr, 64'h100 + 64'(mon_id));
        end
      end
      mon_rv = 4'd0;
      for (int i = 0; i < NUM_APPS; i++) mon_rv[i] = app_resp[i].valid;
      if (mon_rv != 4'd0) begin
        if (exp_resp_id_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_resp: got %b expected none", mon_rv);
        end else begin
          mon_id   = exp_resp_id_q.pop_front();
          mon_data = exp_resp_data_q.pop_front();
          check("resp_valid", 64'(mon_rv), 64'(4'b0001 << mon_id[1:0]));
          check("resp_data", app_resp[mon_id[1:0]].data, mon_data);
        end
      end
      if (quiesce_resp.valid) begin
        if (exp_qr_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_quiesce_resp: got %0h expected none", quiesce_resp.data);
        end else begin
          mon_data = exp_qr_q.pop_front();
          check("quiesce_data", quiesce_resp.data, mon_data);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic v, input logic wr);
    app_req[id].valid   = v;
    app_req[id].isWrite = wr;
    app_req[id].addr    = 64'h100 + 64'(id);
    app_req[id].data    = 64'hD000 + 64'(id);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NUM_APPS; i++) app_req[i] = '0;
  endtask

  task automatic send_resp(input logic [63:0] d, input int id);
    mem_resp.valid = 1'b1;
    mem_resp.data  = d;
    exp_resp_id_q.push_back(8'(id));
    exp_resp_data_q.push_back(d);
    tick();
    mem_resp = '0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < NUM_APPS; i++)
      check({tag, "_app_resp"}, 64'(app_resp[i] == '0), 64'd1);
    check({tag, "_app_grant"}, 64'(app_grant), 64'd0);
    check({tag, "_mem_req"}, 64'(mem_req == '0), 64'd1);
    check({tag, "_quiesce_resp"}, 64'(quiesce_resp == '0), 64'd1);
    check({tag, "_resp_err"}, 64'(resp_err), 64'd0);
    check({tag, "_fifo_cnt"}, 64'(dbg_fifo_cnt), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'(RUN));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_reqs();
    mem_grant   = 1'b1;
    mem_resp    = '0;
    quiesce_req = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // All four apps read: grants 0,1,2,3,0 then in-order responses.
    for (int i = 0; i < NUM_APPS; i++) set_req(i, 1'b1, 1'b0);
    exp_grant_q.push_back(8'd0);
    exp_grant_q.push_back(8'd1);
    exp_grant_q.push_back(8'd2);
    exp_grant_q.push_back(8'd3);
    exp_grant_q.push_back(8'd0);
    repeat (5) tick();
    clear_reqs();
    check("rr_fifo_cnt", 64'(dbg_fifo_cnt), 64'd5);
    send_resp(64'hD0, 0);
    send_resp(64'hD1, 1);
    send_resp(64'hD2, 2);
    send_resp(64'hD3, 3);
    send_resp(64'hD4, 0);
    tick();
    check("rr_fifo_drained", 64'(dbg_fifo_cnt), 64'd0);

    // rr_ptr=1: app1 write then app2 read; only app2 gets a response.
    set_req(1, 1'b1, 1'b1);
    set_req(2, 1'b1, 1'b0);
    exp_grant_q.push_back(8'd1);
    exp_grant_q.push_back(8'd2);
    tick();
    app_req[1].valid = 1'b0;
    check("write_no_push", 64'(dbg_fifo_cnt), 64'd0);
    tick();
    app_req[2].valid = 1'b0;
    check("read_push", 64'(dbg_fifo_cnt), 64'd1);
    send_resp(64'hAA, 2);
    tick();

    // Fill the tag FIFO with 16 reads from app0.
    set_req(0, 1'b1, 1'b0);
    for (int k = 0; k < ORDER_DEPTH; k++) exp_grant_q.push_back(8'd0);
    repeat (ORDER_DEPTH) tick();
    check("full_cnt", 64'(dbg_fifo_cnt), 64'd16);
    #3;
    check("full_masks_read", 64'(mem_req.valid), 64'd0);
    tick();
    set_req(3, 1'b1, 1'b1);
    exp_grant_q.push_back(8'd3);
    tick();
    app_req[3].valid = 1'b0;
    check("full_write_cnt", 64'(dbg_fifo_cnt), 64'd16);
    tick();
    exp_grant_q.push_back(8'd0);
    send_resp(64'hF0, 0);
    app_req[0].valid = 1'b0;
    check("push_pop_full_cnt", 64'(dbg_fifo_cnt), 64'd16);
    for (int k = 0; k < ORDER_DEPTH; k++) send_resp(64'h200 + 64'(k), 0);
    tick();
    check("full_drained", 64'(dbg_fifo_cnt), 64'd0);

    // Response with nothing outstanding.
    mem_resp.valid = 1'b1;
    mem_resp.data  = 64'hEE;
    tick();
    mem_resp = '0;
    check("resp_err_set", 64'(resp_err), 64'd1);
    repeat (3) tick();
    check("resp_err_sticky", 64'(resp_err), 64'd1);
    check("resp_err_cnt", 64'(dbg_fifo_cnt), 64'd0);

    // Asynchronous reset with reads outstanding and a response in flight.
    for (int i = 0; i < NUM_APPS; i++) set_req(i, 1'b1, 1'b0);
    exp_grant_q.push_back(8'd1);
    exp_grant_q.push_back(8'd2);
    exp_grant_q.push_back(8'd3);
    exp_grant_q.push_back(8'd0);
    exp_grant_q.push_back(8'd1);
    exp_grant_q.push_back(8'd2);
    repeat (6) tick();
    clear_reqs();
    check("pre_reset_cnt", 64'(dbg_fifo_cnt), 64'd6);
    mem_resp.valid = 1'b1;
    mem_resp.data  = 64'h55;
    tick();
    mem_resp = '0;
    check("inflight_resp_valid", 64'(app_resp[1].valid), 64'd1);
    check("inflight_resp_data", app_resp[1].data, 64'h55);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Quiesce with three reads outstanding.
    set_req(1, 1'b1, 1'b0);
    set_req(2, 1'b1, 1'b0);
    set_req(3, 1'b1, 1'b0);
    exp_grant_q.push_back(8'd1);
    exp_grant_q.push_back(8'd2);
    exp_grant_q.push_back(8'd3);
    tick();
    app_req[1].valid = 1'b0;
    tick();
    app_req[2].valid = 1'b0;
    tick();
    app_req[3].valid = 1'b0;
    check("quiesce_outstanding", 64'(dbg_fifo_cnt), 64'd3);
    quiesce_req.valid     = 1'b1;
    quiesce_req.isRequest = 1'b1;
    tick();
    quiesce_req = '0;
    check("state_drain", 64'(dbg_state), 64'(DRAIN));
    set_req(0, 1'b1, 1'b0);
    exp_qr_q.push_back(64'd3);
    send_resp(64'h31, 1);
    send_resp(64'h32, 2);
    send_resp(64'h33, 3);
    for (int t = 0; t < 20 && exp_qr_q.size() != 0; t++) tick();
    check("quiesce_resp_seen", 64'(exp_qr_q.size()), 64'd0);
    tick();
    check("state_quiesced", 64'(dbg_state), 64'(QUIESCED));
    repeat (2) tick();
    exp_grant_q.push_back(8'd0);
    quiesce_req.valid     = 1'b1;
    quiesce_req.isRequest = 1'b0;
    tick();
    quiesce_req = '0;
    check("state_run", 64'(dbg_state), 64'(RUN));
    tick();
    app_req[0].valid = 1'b0;
    repeat (3) tick();

    check("grant_q_empty", 64'(exp_grant_q.size()), 64'd0);
    check("resp_q_empty", 64'(exp_resp_id_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
